// File: rtl/dma_pkg.sv
// Shared definitions for the burst DMA engine.
//   - default widths and return-buffer depth
//   - direction encoding for cmd_dir
//   - FSM state type
package dma_pkg;

    localparam int DMA_ADDR_W     = 20;
    localparam int DMA_DATA_W     = 16;
    localparam int DMA_LEN_W      = 16;
    localparam int DMA_STRIDE_W   = 8;
    localparam int DMA_FIFO_DEPTH = 4;

    localparam logic DMA_RD = 1'b1;   // RAM -> rd stream
    localparam logic DMA_WR = 1'b0;   // wr stream -> RAM

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WRITE,
        DONE
    } dma_state_t;

endpackage

// File: rtl/dma_burst_engine_if.sv
// Bus bundle of the burst DMA engine: command channel, single-port RAM
// port, read stream, write stream and status.
//   master : the DMA engine (drives cmd_ready, RAM port, rd stream, status)
//   slave  : the environment (command source, RAM, stream partners)
interface dma_burst_engine_if import dma_pkg::*; #(
    parameter int ADDR_WIDTH   = DMA_ADDR_W,
    parameter int DATA_WIDTH   = DMA_DATA_W,
    parameter int LEN_WIDTH    = DMA_LEN_W,
    parameter int STRIDE_WIDTH = DMA_STRIDE_W
) ();

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_dir;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [LEN_WIDTH-1:0]    cmd_len;
    logic [STRIDE_WIDTH-1:0] cmd_stride;

    logic                    mem_en;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    logic                    rd_valid;
    logic                    rd_ready;
    logic [DATA_WIDTH-1:0]   rd_data;

    logic                    wr_valid;
    logic                    wr_ready;
    logic [DATA_WIDTH-1:0]   wr_data;

    logic                    busy;
    logic                    done;

    modport master (
        input  cmd_valid, cmd_dir, cmd_addr, cmd_len, cmd_stride,
        output cmd_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output rd_valid, rd_data,
        input  rd_ready,
        input  wr_valid, wr_data,
        output wr_ready,
        output busy, done
    );

    modport slave (
        output cmd_valid, cmd_dir, cmd_addr, cmd_len, cmd_stride,
        input  cmd_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  rd_valid, rd_data,
        output rd_ready,
        output wr_valid, wr_data,
        input  wr_ready,
        input  busy, done
    );

endinterface

// File: rtl/dma_return_fifo.sv
// Read-return buffer for the burst DMA engine.
// Synchronous FIFO with same-cycle push/pop (also when full) and an
// occupancy count used by the engine's read-credit check.
// Ports:
//   clk, rst_n        clock, async active-low reset (flushes contents)
//   push, push_data   write side
//   pop               consume head (ignored when empty)
//   head              current head word, 0 while empty
//   empty             no words stored
//   count             words stored, 0..FIFO_DEPTH
module dma_return_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         head,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW:0]           count_q;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PW+1)'(FIFO_DEPTH));
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot a full FIFO needs
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/dma_burst_engine.sv
// Burst DMA between a single-port synchronous RAM and ready/valid streams.
// One command at a time: start address, word count, stride, direction.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          dma_burst_engine_if.master: command channel, RAM port,
//                read stream (RAM -> rd), write stream (wr -> RAM), busy/done
//
// state | meaning
// IDLE  | cmd_ready=1, waiting for a command
// READ  | issuing RAM reads, limited by return-buffer credit
// DRAIN | all reads issued, waiting for the last word to leave the buffer
// WRITE | accepting wr words; one extra cycle after the last while it lands
// DONE  | done pulse, back to IDLE
module dma_burst_engine import dma_pkg::*; #(
    parameter int ADDR_WIDTH   = DMA_ADDR_W,
    parameter int DATA_WIDTH   = DMA_DATA_W,
    parameter int LEN_WIDTH    = DMA_LEN_W,
    parameter int STRIDE_WIDTH = DMA_STRIDE_W,
    parameter int FIFO_DEPTH   = DMA_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dma_burst_engine_if.master   bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    dma_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [LEN_WIDTH-1:0]    rem_q;
    logic [STRIDE_WIDTH-1:0] stride_q;
    logic                    inflight_q;
    logic                    wr_en_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DATA_WIDTH-1:0]   wr_data_q;

    logic [CNT_W-1:0]        fifo_count;
    logic                    fifo_empty;
    logic [DATA_WIDTH-1:0]   fifo_head;

    logic                    cmd_fire;
    logic                    credit_ok;
    logic                    rd_issue;
    logic                    rd_pop;
    logic                    wr_fire;
    logic                    drain_done;
    logic [ADDR_WIDTH-1:0]   addr_inc;

    assign addr_inc  = addr_q + ADDR_WIDTH'(stride_q);   // wraps modulo 2^ADDR_WIDTH

    // Reads already in the RAM pipeline hold a buffer slot; a pop in this
    // cycle is deliberately not credited until the next one.
    assign credit_ok = (int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH;

    assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
    assign rd_issue  = (state_q == READ) && (rem_q != '0) && credit_ok;
    assign rd_pop    = !fifo_empty && bus.rd_ready;
    assign wr_fire   = (state_q == WRITE) && (rem_q != '0) && bus.wr_valid;

    // last word leaves the buffer this cycle and nothing is still in flight
    assign drain_done = !inflight_q &&
                        (fifo_empty || ((fifo_count == CNT_W'(1)) && rd_pop));

    dma_return_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (bus.mem_rdata),
        .pop       (rd_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (bus.cmd_len == '0)          state_d = DONE;
                    else if (bus.cmd_dir == DMA_RD) state_d = READ;
                    else                            state_d = WRITE;
                end
            end
            READ:  if (rd_issue && (rem_q == LEN_WIDTH'(1))) state_d = DRAIN;
            DRAIN: if (drain_done)                           state_d = DONE;
            // rem_q hits zero on the last handshake; leave once that word is written
            WRITE: if (rem_q == '0)                          state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Direction is carried by the READ/WRITE state, so it needs no register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            rem_q      <= '0;
            stride_q   <= '0;
            inflight_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            inflight_q <= rd_issue;
            wr_en_q    <= wr_fire;
            if (cmd_fire) begin
                addr_q   <= bus.cmd_addr;
                rem_q    <= bus.cmd_len;
                stride_q <= bus.cmd_stride;
            end else if (rd_issue || wr_fire) begin
                addr_q <= addr_inc;
                rem_q  <= rem_q - 1'b1;
            end
            if (wr_fire) begin
                wr_addr_q <= addr_q;
                wr_data_q <= bus.wr_data;
            end
        end
    end

    // cmd_ready is held low while rst_n is asserted
    assign bus.cmd_ready = rst_n && (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.wr_ready  = (state_q == WRITE) && (rem_q != '0);
    assign bus.mem_en    = rd_issue || wr_en_q;
    assign bus.mem_we    = wr_en_q;
    assign bus.mem_addr  = rd_issue ? addr_q : wr_addr_q;
    assign bus.mem_wdata = wr_data_q;
    assign bus.rd_valid  = !fifo_empty;
    assign bus.rd_data   = fifo_head;

endmodule

// File: tb/tb_dma_burst_engine.sv
module tb_dma_burst_engine;
    import dma_pkg::*;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int LW = 16;
    localparam int SW = 8;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dma_burst_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                          .STRIDE_WIDTH(SW)) bus ();

    dma_burst_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW),
                       .STRIDE_WIDTH(SW), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: RAM[i] = i (low 16 bits), one-cycle read latency
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= bus.mem_addr[15:0];
    end

    int          rd_cyc[$];
    logic [15:0] rd_dat[$];
    int          done_cyc[$];
    int          acc_cyc[$];
    int          wr_cyc[$];
    logic [19:0] wr_adr[$];
    logic [15:0] wr_dat[$];
    int          n_en;
    int          rd_issues;
    int          popped;
    int          first_issue;
    int          max_out;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_en) n_en++;
            if (bus.mem_en && !bus.mem_we) begin
                if (rd_issues == 0) first_issue = cyc;
                rd_issues++;
            end
            if (rd_issues - popped > max_out) max_out = rd_issues - popped;
            if (bus.rd_valid && bus.rd_ready) begin
                rd_cyc.push_back(cyc);
                rd_dat.push_back(bus.rd_data);
                popped++;
            end
            if (bus.mem_en && bus.mem_we) begin
                wr_cyc.push_back(cyc);
                wr_adr.push_back(bus.mem_addr);
                wr_dat.push_back(bus.mem_wdata);
            end
            if (bus.done) done_cyc.push_back(cyc);
            if (bus.cmd_valid && bus.cmd_ready) acc_cyc.push_back(cyc);
        end
    end

    task automatic clear_logs();
        rd_cyc.delete(); rd_dat.delete(); done_cyc.delete(); acc_cyc.delete();
        wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
        n_en = 0; rd_issues = 0; popped = 0; first_issue = -1; max_out = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ctl"}, 32'({bus.cmd_ready, bus.mem_en, bus.mem_we, bus.rd_valid,
                                bus.wr_ready, bus.busy, bus.done}), 0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
        chk({tag, "_wdata"}, 32'(bus.mem_wdata), 0);
        chk({tag, "_rdata"}, 32'(bus.rd_data), 0);
    endtask

    task automatic send_cmd(input logic dir, input logic [19:0] addr, input logic [15:0] len,
                            input logic [7:0] stride, output int t0);
        chk("cmd_ready_before_cmd", 32'(bus.cmd_ready), 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_dir    = dir;
        bus.cmd_addr   = addr;
        bus.cmd_len    = len;
        bus.cmd_stride = stride;
        t0 = cyc;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input bit toggle);
        int k = 0;
        while (done_cyc.size() < n && k < budget) begin
            if (toggle) bus.rd_ready = ~bus.rd_ready;
            tick();
            k++;
        end
        chk("done_within_budget", 32'(done_cyc.size()), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int t0;
        int last_hs;
        int sent;
        int p;
        int nacc;
        int k;
        logic [6:0] pat;
        logic [19:0] wexp_a [4];

        bus.cmd_valid = 1'b0; bus.cmd_dir = 1'b0; bus.cmd_addr = '0;
        bus.cmd_len = '0; bus.cmd_stride = '0;
        bus.rd_ready = 1'b0; bus.wr_valid = 1'b0; bus.wr_data = '0;
        clear_logs();

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outs("in_reset");
        rst_n = 1'b1;
        tick();
        chk("cmd_ready_after_reset", 32'(bus.cmd_ready), 1);
        chk("busy_after_reset", 32'(bus.busy), 0);

        // read len=5 from 0x10, stride 1, rd_ready high
        clear_logs();
        bus.rd_ready = 1'b1;
        send_cmd(DMA_RD, 20'h00010, 16'd5, 8'd1, t0);
        chk("rd5_busy", 32'(bus.busy), 1);
        wait_done(1, 40, 1'b0);
        chk("rd5_count", 32'(rd_dat.size()), 5);
        for (int i = 0; i < 5; i++) begin
            chk("rd5_data", (i < rd_dat.size()) ? 32'(rd_dat[i]) : 32'hDEAD, 32'(16'h10 + i));
            chk("rd5_cycle", (i < rd_cyc.size()) ? 32'(rd_cyc[i]) : 32'hDEAD, 32'(t0 + 3 + i));
        end
        chk("rd5_first_en", 32'(first_issue), 32'(t0 + 1));
        chk("rd5_done_cycle", (done_cyc.size() > 0) ? 32'(done_cyc[0]) : 32'hDEAD, 32'(t0 + 8));
        chk("rd5_mem_en", 32'(n_en), 5);

        // read len=8 stride 3: full stall first, then rd_ready toggling
        clear_logs();
        bus.rd_ready = 1'b0;
        send_cmd(DMA_RD, 20'h00000, 16'd8, 8'd3, t0);
        repeat (10) tick();
        chk("stall_issued", 32'(n_en), FD);
        chk("stall_rd_valid", 32'(bus.rd_valid), 1);
        wait_done(1, 100, 1'b1);
        chk("rd8_count", 32'(rd_dat.size()), 8);
        for (int i = 0; i < 8; i++)
            chk("rd8_data", (i < rd_dat.size()) ? 32'(rd_dat[i]) : 32'hDEAD, 32'(3 * i));
        chk("rd8_outstanding_ok", 32'(max_out <= FD), 1);
        chk("rd8_mem_en", 32'(n_en), 8);

        // write len=4 at 0xFFFFE with wr_valid gaps, address wraps
        clear_logs();
        bus.rd_ready = 1'b1;
        send_cmd(DMA_WR, 20'hFFFFE, 16'd4, 8'd1, t0);
        pat = 7'b1001101;
        sent = 0; p = 0; last_hs = -1;
        while (sent < 4 && p < 20) begin
            bus.wr_valid = pat[p % 7];
            bus.wr_data  = 16'(16'hA0 + sent);
            if (bus.wr_valid && bus.wr_ready) begin
                last_hs = cyc;
                sent++;
            end
            tick();
            p++;
        end
        bus.wr_valid = 1'b0;
        chk("wr_sent", 32'(sent), 4);
        chk("wr_ready_after_last", 32'(bus.wr_ready), 0);
        wait_done(1, 20, 1'b0);
        chk("wr_done_cycle", (done_cyc.size() > 0) ? 32'(done_cyc[0]) : 32'hDEAD, 32'(last_hs + 2));
        chk("wr_count", 32'(wr_adr.size()), 4);
        wexp_a[0] = 20'hFFFFE; wexp_a[1] = 20'hFFFFF; wexp_a[2] = 20'h00000; wexp_a[3] = 20'h00001;
        for (int i = 0; i < 4; i++) begin
            chk("wr_addr", (i < wr_adr.size()) ? 32'(wr_adr[i]) : 32'hDEAD, 32'(wexp_a[i]));
            chk("wr_data", (i < wr_dat.size()) ? 32'(wr_dat[i]) : 32'hDEAD, 32'(16'hA0 + i));
        end
        chk("wr_last_cycle", (wr_cyc.size() == 4) ? 32'(wr_cyc[3]) : 32'hDEAD, 32'(last_hs + 1));

        // len=0
        clear_logs();
        send_cmd(DMA_RD, 20'h00123, 16'd0, 8'd1, t0);
        chk("len0_done", 32'(bus.done), 1);
        tick();
        chk("len0_done_low", 32'(bus.done), 0);
        chk("len0_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("len0_mem_en", 32'(n_en), 0);

        // reset in the middle of a len=10 read, then a fresh len=2 read
        clear_logs();
        bus.rd_ready = 1'b0;
        send_cmd(DMA_RD, 20'h00200, 16'd10, 8'd1, t0);
        repeat (3) tick();
        chk("pre_reset_rd_valid", 32'(bus.rd_valid), 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mid_reset");
        tick();
        chk_reset_outs("mid_reset_clk");
        rst_n = 1'b1;
        tick();
        clear_logs();
        bus.rd_ready = 1'b1;
        send_cmd(DMA_RD, 20'h00100, 16'd2, 8'd1, t0);
        wait_done(1, 30, 1'b0);
        chk("post_reset_count", 32'(rd_dat.size()), 2);
        chk("post_reset_d0", (rd_dat.size() > 0) ? 32'(rd_dat[0]) : 32'hDEAD, 32'h100);
        chk("post_reset_d1", (rd_dat.size() > 1) ? 32'(rd_dat[1]) : 32'hDEAD, 32'h101);

        // back-to-back, cmd_valid held high, stride 0 at 0x55
        clear_logs();
        bus.cmd_valid = 1'b1; bus.cmd_dir = DMA_RD; bus.cmd_addr = 20'h00055;
        bus.cmd_len = 16'd3; bus.cmd_stride = 8'd0;
        nacc = 0; k = 0;
        while (nacc < 2 && k < 60) begin
            if (bus.cmd_ready) nacc++;
            tick();
            k++;
        end
        bus.cmd_valid = 1'b0;
        wait_done(2, 40, 1'b0);
        chk("b2b_accepts", 32'(acc_cyc.size()), 2);
        chk("b2b_second_accept",
            (acc_cyc.size() > 1 && done_cyc.size() > 0) ? 32'(acc_cyc[1] - done_cyc[0]) : 32'hDEAD, 1);
        chk("b2b_count", 32'(rd_dat.size()), 6);
        for (int i = 0; i < 6; i++)
            chk("b2b_data", (i < rd_dat.size()) ? 32'(rd_dat[i]) : 32'hDEAD, 32'h55);
        chk("b2b_mem_en", 32'(n_en), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_burst_engine.md
# dma_burst_engine

Parametrised burst DMA between main memory and the CNN datapath. It accepts one transfer command at a time: a start address, a word count, an address stride and a direction. It then either streams words out of a single-port synchronous RAM onto a ready/valid read stream, or writes words from a ready/valid input stream into the RAM. It replaces fixed-block, unhandshaked memory access, sitting between the RAM and the layer engines (feature-map and weight loaders, result write-back).

## Interface
- ADDR_WIDTH, 20, RAM word-address width
- DATA_WIDTH, 16, word width
- LEN_WIDTH, 16, width of word-count field
- STRIDE_WIDTH, 8, width of unsigned address stride
- FIFO_DEPTH, 4, read-return buffer depth; must be a power of two and ≥3

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine idle, command accepted when valid&ready
- cmd_dir  in  1  1 = read RAM→rd stream, 0 = write wr stream→RAM
- cmd_addr  in  ADDR_WIDTH  first word address
- cmd_len  in  LEN_WIDTH  word count; 0 is legal
- cmd_stride  in  STRIDE_WIDTH  address increment per word (0 = repeat same address)
- mem_en  out  1  RAM access strobe
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  write data
- mem_rdata  in  DATA_WIDTH  read data, valid exactly one cycle after mem_en&!mem_we
- rd_valid / rd_ready / rd_data  out/in/out  1/1/DATA_WIDTH  read stream
- wr_valid / wr_ready / wr_data  in/out/in  1/1/DATA_WIDTH  write stream
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end

## Operation
- States:
  - IDLE: cmd_ready=1. On accept, latch addr/len/stride/dir. len=0 → DONE. Otherwise dir=1 → READ, dir=0 → WRITE.
  - READ: issue one RAM read per cycle while issued<len and (fifo_count + inflight) < FIFO_DEPTH. mem_rdata is pushed into the FIFO one cycle after issue. Once all reads are issued → DRAIN.
  - DRAIN: wait until inflight=0 and FIFO empty (last word popped) → DONE.
  - WRITE: wr_ready=1 while words remain. Each wr handshake registers mem_en=1, mem_we=1, mem_addr, mem_wdata for the next cycle. The last handshake → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Address arithmetic: addr_next = addr + zero-extended stride, modulo 2^ADDR_WIDTH (wraps silently, no error).
- Counters are LEN_WIDTH wide; len up to 2^LEN_WIDTH−1.
- rd_data is the FIFO head; rd_valid = FIFO non-empty. Data order is strictly issue order.
- The FIFO never overflows: the credit check counts in-flight reads.
- busy=1 in all states except IDLE.
- Commands offered while busy are held off (cmd_ready=0), not dropped.

## Timing
- Reset values: cmd_ready=1 once rst_n deasserts. mem_en, mem_we, mem_addr, mem_wdata, rd_valid, rd_data, wr_ready, busy and done are all 0. FIFO is empty.
- Read, accept at cycle 0:
  - first mem_en at cycle 1
  - first rd_valid at cycle 3
- Sustained read throughput is 1 word/cycle when rd_ready is held high.
- rd_ready low stalls issue within FIFO_DEPTH words. Issue resumes the cycle after credit frees.
- Read done: the cycle after the final rd handshake.
- Write, handshake in cycle k: RAM write occurs in cycle k+1. done is asserted in cycle k+2 for the last word.
- len=0: done at cycle 1 after accept, no mem_en.
- A new command can be accepted the cycle after done.
- rst_n low mid-transfer: immediate return to IDLE. The FIFO and in-flight tracking are flushed, all outputs go to reset values, and the partially completed transfer is abandoned.
- Simultaneous FIFO push and pop keeps the count unchanged, including when the FIFO is full.

## Structure
- Shared package dma_pkg:
  - state enum (IDLE, READ, DRAIN, WRITE, DONE)
  - default width constants
  - dir encoding constants DMA_RD=1, DMA_WR=0
- One sub-module, dma_return_fifo: synchronous FIFO parametrised by DATA_WIDTH and FIFO_DEPTH, with count output and same-cycle push/pop.
- Top-level holds the FSM, address/counter datapath, credit logic and write-path registers.

## Test plan
- Read len=5, addr=0x00010, stride=1, RAM[i]=i, rd_ready=1 → rd_data 0x10..0x14 on cycles 3..7, one done pulse at cycle 8, exactly 5 mem_en.
- Read len=8, stride=3, rd_ready toggling 1/0 → words RAM[0,3,…,21] in order, no loss or duplication, at most FIFO_DEPTH reads outstanding.
- Write len=4, addr=0xFFFFE, stride=1, wr_data 0xA0..0xA3 with wr_valid gaps → writes land at 0xFFFFE, 0xFFFFF, 0x00000, 0x00001 (wrap).
- len=0 command → done at cycle 1, no mem_en, cmd_ready=1 at cycle 2.
- rst_n asserted in the middle of a len=10 read → all outputs 0 during reset. After release, a fresh len=2 read returns correct data with no stale FIFO words.
- Back-to-back commands with cmd_valid held high → the second command is accepted only the cycle after done. stride=0 repeats the same address len times.
